multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit that sequences the processor datapath.
- Owns the program counter (PC) register and fetches instructions from instruction memory using a ready handshake.
- Decodes the opcode, drives the ALU selector and the register-file write enable, and resolves branches using the ALU zero flag.
- Sits between instruction memory, the PC/IR path, the ALU (i_op1/i_op2/selector/Result_op/Zeroflag) and the register file.

Parameters:
PC_W, 8, program counter width in bits; the PC wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RST  in  1  asynchronous, active-high reset
i_start  in  1  leave IDLE and begin fetching
i_instr  in  16  instruction word from memory; valid when i_mem_ready=1
i_mem_ready  in  1  instruction memory data valid
i_zero  in  1  ALU Zeroflag
o_pc  out  PC_W  current PC, used as the instruction memory address
o_mem_rd  out  1  instruction read request
o_ir_we  out  1  IR load strobe
o_alu_sel  out  3  ALU selector
o_reg_we  out  1  register file write enable
o_state  out  3  current state code
o_halt  out  1  processor halted
o_illegal  out  1  one-cycle pulse on an undefined opcode
o_retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (asynchronous, on RST=1):
  - state=IDLE, PC=RESET_PC, IR=0, o_retired=0.
  - All control outputs are 0.
  - A reset asserted mid-instruction aborts that instruction immediately; no write enable survives it.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- Control outputs are Moore decodes of the state and the internal IR. The PC, IR and counter are registers.
- IDLE: all outputs 0. Go to FETCH when i_start=1; otherwise stay.
- FETCH:
  - o_mem_rd=1.
  - While i_mem_ready=0: stay, PC unchanged (any number of wait cycles).
  - When i_mem_ready=1: o_ir_we=1 in the same cycle. On that edge IR<=i_instr and PC<=PC+1 (wraps), then go to DECODE.
- DECODE: uses opcode=IR[15:12], imm=IR[7:0].
  - 0000–0100 (ADD, SUB, AND, OR, SLT) -> EXECUTE.
  - 1000 BEQ -> EXECUTE.
  - 1001 JMP: PC<=imm[PC_W-1:0]; retire; go to FETCH.
  - 1111 HALT: retire; go to HALT.
  - Any other opcode: o_illegal=1 for this cycle; treat as NOP (counts as retired); go to FETCH.
- EXECUTE:
  - R-type: o_alu_sel=opcode[2:0]; go to WRITEBACK.
  - BEQ: o_alu_sel=001 (SUB).
    - i_zero is sampled on this edge.
    - If i_zero=1: PC<=PC+sext(imm). This is relative to the already-incremented PC, computed modulo 2^PC_W.
    - Retire, then go to FETCH.
- WRITEBACK: o_alu_sel held at its EXECUTE value; o_reg_we=1 for exactly this cycle; retire; go to FETCH.
- o_alu_sel is 000 in every state other than EXECUTE and WRITEBACK.
- HALT:
  - o_halt=1, all other control outputs 0, PC frozen.
  - i_start is ignored; only RST leaves this state.
- Retire means o_retired<=o_retired+1 on the exit edge; it wraps at 2^CNT_W.
- Latency with zero wait states:
  - R-type = 4 cycles.
  - BEQ = 3 cycles.
  - JMP, HALT and illegal opcodes = 2 cycles.
  - Each memory wait cycle adds 1.
- i_start is only examined in IDLE. i_zero is only examined in BEQ EXECUTE.

Test Plan:
- Reset, then i_start=1 with memory returning ADD (0x0000) and i_mem_ready=1 always -> o_state sequence 1,2,3,4,1; o_alu_sel=000 in cycles 3–4; o_reg_we=1 only in WRITEBACK; o_pc 0->1; o_retired=1.
- BEQ 0x80FE (offset -2) at PC=5 with i_zero=1 -> PC becomes 6, then 4, and the next fetch is at 4. Repeat with i_zero=0 -> next fetch at 6; o_alu_sel=001 during EXECUTE.
- JMP 0x9042 -> o_pc=0x42 after DECODE; no EXECUTE state visited; o_reg_we never asserted.
- Hold i_mem_ready=0 for 3 cycles in FETCH -> o_mem_rd stays 1, o_pc and IR unchanged, o_ir_we=0. Release -> o_ir_we pulses once.
- Opcode 0x7 -> o_illegal high for exactly 1 cycle, returns to FETCH, o_retired increments. Then HALT 0xF000 -> o_halt=1 and o_pc frozen for 10 cycles despite i_start=1.
- Assert RST asynchronously during WRITEBACK -> o_reg_we drops immediately; o_state=0, o_pc=RESET_PC, o_retired=0. PC wrap: JMP 0xFF then fetch -> o_pc=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: owns PC/IR, sequences fetch/decode/execute/writeback, counts retired instructions.
// Latency: R-type 4, BEQ 3, JMP/HALT/illegal 2 cycles; instruction-memory stalls hold FETCH one cycle each.
module multicycle_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_start,
    input  logic [15:0]      i_instr,
    input  logic             i_mem_ready,
    input  logic             i_zero,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_mem_rd,
    output logic             o_ir_we,
    output logic [2:0]       o_alu_sel,
    output logic             o_reg_we,
    output logic [2:0]       o_state,
    output logic             o_halt,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [15:0]       ir, ir_nxt;
    logic [CNT_W-1:0]  retired, retired_nxt;

    logic [3:0]        opcode;
    logic [7:0]        imm;
    logic [PC_W-1:0]   jmp_tgt;
    logic [PC_W-1:0]   br_off;
    logic              unused_ir_bits;

    assign opcode         = ir[15:12];
    assign imm            = ir[7:0];
    assign jmp_tgt        = PC_W'(imm);
    assign br_off         = PC_W'($signed(imm));
    assign unused_ir_bits = ^ir[11:8];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            retired <= retired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        retired_nxt = retired;
        o_mem_rd    = 1'b0;
        o_ir_we     = 1'b0;
        o_alu_sel   = 3'b000;
        o_reg_we    = 1'b0;
        o_halt      = 1'b0;
        o_illegal   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                o_mem_rd = 1'b1;
                if (i_mem_ready) begin
                    o_ir_we   = 1'b1;
                    ir_nxt    = i_instr;
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, OP_BEQ: begin
                        state_nxt = S_EXECUTE;
                    end
                    OP_JMP: begin
                        pc_nxt      = jmp_tgt;
                        retired_nxt = retired + CNT_W'(1);
                        state_nxt   = S_FETCH;
                    end
                    OP_HALT: begin
                        retired_nxt = retired + CNT_W'(1);
                        state_nxt   = S_HALT;
                    end
                    default: begin
                        // Undefined opcodes retire as NOPs.
                        o_illegal   = 1'b1;
                        retired_nxt = retired + CNT_W'(1);
                        state_nxt   = S_FETCH;
                    end
                endcase
            end
            S_EXECUTE: begin
                if (opcode == OP_BEQ) begin
                    o_alu_sel = 3'b001;
                    // Target is relative to the PC already advanced past the branch.
                    if (i_zero) pc_nxt = pc + br_off;
                    retired_nxt = retired + CNT_W'(1);
                    state_nxt   = S_FETCH;
                end else begin
                    o_alu_sel = opcode[2:0];
                    state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                o_alu_sel   = opcode[2:0];
                o_reg_we    = 1'b1;
                retired_nxt = retired + CNT_W'(1);
                state_nxt   = S_FETCH;
            end
            S_HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_pc      = pc;
    assign o_state   = state;
    assign o_retired = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle directed vectors queue their expected outputs,
// a negedge monitor pops and compares; async reset is also checked mid-cycle.
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_instr = 16'h0000;
    logic        i_mem_ready = 1'b0;
    logic        i_zero = 1'b0;
    logic [7:0]  o_pc;
    logic        o_mem_rd;
    logic        o_ir_we;
    logic [2:0]  o_alu_sel;
    logic        o_reg_we;
    logic [2:0]  o_state;
    logic        o_halt;
    logic        o_illegal;
    logic [15:0] o_retired;

    multicycle_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_start     (i_start),
        .i_instr     (i_instr),
        .i_mem_ready (i_mem_ready),
        .i_zero      (i_zero),
        .o_pc        (o_pc),
        .o_mem_rd    (o_mem_rd),
        .o_ir_we     (o_ir_we),
        .o_alu_sel   (o_alu_sel),
        .o_reg_we    (o_reg_we),
        .o_state     (o_state),
        .o_halt      (o_halt),
        .o_illegal   (o_illegal),
        .o_retired   (o_retired)
    );

    always #5 CLK = ~CLK;

    // flags = {mem_rd, ir_we, reg_we, halt, illegal}
    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  pc;
        logic [15:0] ret;
        logic [2:0]  sel;
        logic [4:0]  fl;
    } vec_t;

    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] RD = 5'b10000;
    localparam logic [4:0] FR = 5'b11000;
    localparam logic [4:0] WE = 5'b00100;
    localparam logic [4:0] HL = 5'b00010;
    localparam logic [4:0] IL = 5'b00001;

    vec_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;

    task automatic cyc(input logic st, input logic rdy, input logic z, input logic [15:0] instr,
                       input logic [2:0] es, input logic [7:0] epc, input logic [15:0] eret,
                       input logic [2:0] esel, input logic [4:0] efl);
        @(posedge CLK);
        #1;
        i_start     = st;
        i_mem_ready = rdy;
        i_zero      = z;
        i_instr     = instr;
        expq.push_back({es, epc, eret, esel, efl});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            vec_t e;
            vec_t a;
            @(negedge CLK);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                a = {o_state, o_pc, o_retired, o_alu_sel,
                     {o_mem_rd, o_ir_we, o_reg_we, o_halt, o_illegal}};
                checks++;
                ncyc++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cyc%0d: got st=%0d pc=%h ret=%0d sel=%b fl=%b, expected st=%0d pc=%h ret=%0d sel=%b fl=%b",
                             ncyc, a.st, a.pc, a.ret, a.sel, a.fl, e.st, e.pc, e.ret, e.sel, e.fl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0, 3'b000, N);
        cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0, 3'b000, N);
        RST = 1'b0;

        // ADD: 1,2,3,4 then FETCH
        cyc(1, 0, 0, 16'h0000, 0, 8'h00, 0, 3'b000, N);
        cyc(0, 1, 0, 16'h0000, 1, 8'h00, 0, 3'b000, FR);
        cyc(0, 1, 0, 16'h0000, 2, 8'h01, 0, 3'b000, N);
        cyc(0, 0, 0, 16'h0000, 3, 8'h01, 0, 3'b000, N);
        cyc(0, 0, 0, 16'h0000, 4, 8'h01, 0, 3'b000, WE);
        // OR: selector 011 through EXECUTE and WRITEBACK, i_zero ignored
        cyc(0, 1, 0, 16'h3123, 1, 8'h01, 1, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h02, 1, 3'b000, N);
        cyc(0, 0, 1, 16'h0000, 3, 8'h02, 1, 3'b011, N);
        cyc(0, 0, 0, 16'h0000, 4, 8'h02, 1, 3'b011, WE);
        // JMP 5
        cyc(0, 1, 0, 16'h9005, 1, 8'h02, 2, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h03, 2, 3'b000, N);
        // BEQ -2 at PC 5, taken: 6 -> 4
        cyc(0, 1, 0, 16'h80FE, 1, 8'h05, 3, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h06, 3, 3'b000, N);
        cyc(0, 0, 1, 16'h0000, 3, 8'h06, 3, 3'b001, N);
        // BEQ -2 at PC 4, not taken: stays 5
        cyc(0, 1, 0, 16'h80FE, 1, 8'h04, 4, 3'b000, FR);
        cyc(0, 0, 1, 16'h0000, 2, 8'h05, 4, 3'b000, N);
        cyc(0, 0, 0, 16'h0000, 3, 8'h05, 4, 3'b001, N);
        // JMP 0x42, no EXECUTE
        cyc(0, 1, 0, 16'h9042, 1, 8'h05, 5, 3'b000, FR);
        cyc(0, 0, 1, 16'h0000, 2, 8'h06, 5, 3'b000, N);
        // Three memory wait cycles, then illegal opcode 0x7
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 16'hF000, 1, 8'h42, 6, 3'b000, RD);
        cyc(0, 1, 0, 16'h7000, 1, 8'h42, 6, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h43, 6, 3'b000, IL);
        // JMP 0xFF, fetch there wraps PC to 0; OR into WRITEBACK
        cyc(0, 1, 0, 16'h90FF, 1, 8'h43, 7, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h44, 7, 3'b000, N);
        cyc(0, 1, 0, 16'h3000, 1, 8'hFF, 8, 3'b000, FR);
        cyc(0, 0, 0, 16'h0000, 2, 8'h00, 8, 3'b000, N);
        cyc(0, 0, 0, 16'h0000, 3, 8'h00, 8, 3'b011, N);
        cyc(0, 0, 0, 16'h0000, 4, 8'h00, 8, 3'b011, WE);

        // Asynchronous reset in the middle of WRITEBACK
        #7;
        RST = 1'b1;
        #1;
        chk("arst_state",   32'(o_state),   32'd0);
        chk("arst_reg_we",  32'(o_reg_we),  32'd0);
        chk("arst_alu_sel", 32'(o_alu_sel), 32'd0);
        chk("arst_pc",      32'(o_pc),      32'd0);
        chk("arst_retired", 32'(o_retired), 32'd0);
        cyc(0, 0, 0, 16'h0000, 0, 8'h00, 0, 3'b000, N);
        RST = 1'b0;

        // HALT: frozen for 10 cycles despite i_start
        cyc(1, 0, 0, 16'h0000, 0, 8'h00, 0, 3'b000, N);
        cyc(0, 1, 0, 16'hF000, 1, 8'h00, 0, 3'b000, FR);
        cyc(1, 0, 0, 16'h0000, 2, 8'h01, 0, 3'b000, N);
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 1, 16'h0000, 5, 8'h01, 1, 3'b000, HL);

        repeat (2) @(posedge CLK);
        chk("drain", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
